// File: rtl/shift_concat_seq_pkg.sv
// Shared types and constants for the shift-and-concatenate engine.
package shift_concat_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_concat_step.sv
// One shift step: moves base one position and inserts new_bit at the vacated end.
module shift_concat_step
    import shift_concat_seq_pkg::*;
#(
    parameter int unsigned W = 12
) (
    input  logic [W-1:0] base,
    input  logic         new_bit,
    input  logic         dir,
    output logic [W-1:0] shifted_c,
    output logic         discarded_c
);

    always_comb begin
        shifted_c   = {base[W-2:0], new_bit};
        discarded_c = base[W-1];
        if (dir == DIR_RIGHT) begin
            shifted_c   = {new_bit, base[W-1:1]};
            discarded_c = base[0];
        end
    end

endmodule

// File: rtl/shift_concat_seq.sv
// Sequential shift-and-concatenate engine: D single-bit shifts of a W-bit register,
// with optional per-step substitution of an externally adjusted value.
module shift_concat_seq
    import shift_concat_seq_pkg::*;
#(
    parameter  int unsigned W  = 12,
    parameter  int unsigned D  = 12,
    localparam int unsigned CW = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          dir,
    input  logic [W-1:0]  init,
    input  logic [D-1:0]  src,
    input  logic          adj_en,
    input  logic [W-1:0]  adj_val,
    output logic [W-1:0]  saida,
    output logic          descartado,
    output logic [CW-1:0] passo,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [D-1:0]  src_q;
    logic          dir_q;
    logic          load;
    logic [W-1:0]  saida_d;
    logic          desc_d;
    logic [CW-1:0] passo_d;
    logic [W-1:0]  base;
    logic [CW-1:0] src_idx;
    logic          new_bit;
    logic [W-1:0]  step_word;
    logic          step_bit;

    // Left consumes the source MSB-first, right consumes it LSB-first.
    always_comb begin
        base    = adj_en ? adj_val : saida;
        src_idx = (dir_q == DIR_RIGHT) ? passo : CW'(D - 1) - passo;
        new_bit = 1'b0;
        for (int unsigned i = 0; i < D; i++) begin
            if (CW'(i) == src_idx) begin
                new_bit = src_q[i];
            end
        end
    end

    shift_concat_step #(.W(W)) u_step (
        .base        (base),
        .new_bit     (new_bit),
        .dir         (dir_q),
        .shifted_c   (step_word),
        .discarded_c (step_bit)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        saida_d = saida;
        desc_d  = descartado;
        passo_d = passo;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    saida_d = init;
                    passo_d = '0;
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    saida_d = step_word;
                    desc_d  = step_bit;
                    passo_d = passo + CW'(1);
                    if (passo == CW'(D - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dir_q      <= 1'b0;
            saida      <= '0;
            descartado <= 1'b0;
            passo      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            saida      <= saida_d;
            descartado <= desc_d;
            passo      <= passo_d;
            busy       <= (state_d == SHIFT);
            done       <= (state_d == DONE);
            if (load) begin
                src_q <= src;
                dir_q <= dir;
            end
        end
    end

endmodule

// File: tb/tb_shift_concat_seq.sv
// Directed self-checking bench for shift_concat_seq (W=12, D=12).
module tb_shift_concat_seq;

    localparam int unsigned W  = 12;
    localparam int unsigned D  = 12;
    localparam int unsigned CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dir = 1'b0;
    logic [W-1:0]  init = '0;
    logic [D-1:0]  src = '0;
    logic          adj_en = 1'b0;
    logic [W-1:0]  adj_val = '0;
    logic [W-1:0]  saida;
    logic          descartado;
    logic [CW-1:0] passo;
    logic          busy;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cnt, done_cnt, done_at, dcnt;

    shift_concat_seq #(.W(W), .D(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .dir        (dir),
        .init       (init),
        .src        (src),
        .adj_en     (adj_en),
        .adj_val    (adj_val),
        .saida      (saida),
        .descartado (descartado),
        .passo      (passo),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] i, input logic [D-1:0] s, input logic d);
        init  = i;
        src   = s;
        dir   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (2) tick();
        check("rst_saida", 32'(saida), 32'h0);
        check("rst_desc",  32'(descartado), 32'h0);
        check("rst_passo", 32'(passo), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_done",  32'(done), 32'h0);
        rst = 1'b0;
        tick();

        // Basic left run: timing of busy and done
        start_op(12'h000, 12'hA5C, 1'b0);
        check("t1_busy0",  32'(busy), 32'h1);
        check("t1_passo0", 32'(passo), 32'h0);
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        for (int k = 0; k < 16; k++) begin
            if (busy) busy_cnt++;
            if (done) begin done_cnt++; done_at = k; end
            tick();
        end
        check("t1_busy_cycles", 32'(busy_cnt), 32'd12);
        check("t1_done_count",  32'(done_cnt), 32'd1);
        check("t1_done_at",     32'(done_at), 32'd12);
        check("t1_saida",       32'(saida), 32'hA5C);
        check("t1_passo",       32'(passo), 32'd12);

        // All ones shifted out to the left
        start_op(12'hFFF, 12'h000, 1'b0);
        dcnt = 0;
        repeat (12) begin
            tick();
            if (descartado) dcnt++;
        end
        check("t2_desc_ones", 32'(dcnt), 32'd12);
        check("t2_saida",     32'(saida), 32'h000);
        check("t2_done",      32'(done), 32'h1);
        tick();

        // Right shift, source LSB-first
        start_op(12'h000, 12'h001, 1'b1);
        tick();
        check("t3_step1", 32'(saida), 32'h800);
        dcnt = descartado ? 1 : 0;
        repeat (11) begin
            tick();
            if (descartado) dcnt++;
        end
        check("t3_saida", 32'(saida), 32'h001);
        check("t3_desc",  32'(dcnt), 32'd0);
        tick();

        // Adjusted value substituted on step 3
        start_op(12'h000, 12'hFFF, 1'b0);
        tick();
        tick();
        check("t4_step2", 32'(saida), 32'h003);
        adj_en = 1'b1; adj_val = 12'h000;
        tick();
        adj_en = 1'b0;
        check("t4_step3", 32'(saida), 32'h001);
        repeat (9) tick();
        check("t4_saida", 32'(saida), 32'h3FF);
        check("t4_done",  32'(done), 32'h1);
        tick();

        // Start re-asserted mid-operation is ignored
        start_op(12'h000, 12'hA5C, 1'b0);
        repeat (4) tick();
        start = 1'b1; init = 12'hFFF; src = 12'h000;
        tick();
        start = 1'b0;
        check("t5_step5", 32'(saida), 32'h014);
        repeat (7) tick();
        check("t5_saida", 32'(saida), 32'hA5C);
        check("t5_done",  32'(done), 32'h1);
        tick();

        // Abort after five steps, with AdjEn also high
        start_op(12'h000, 12'hA5C, 1'b0);
        repeat (5) tick();
        abort = 1'b1; adj_en = 1'b1; adj_val = 12'hFFF;
        tick();
        abort = 1'b0; adj_en = 1'b0;
        check("t6_busy",  32'(busy), 32'h0);
        check("t6_saida", 32'(saida), 32'h014);
        check("t6_passo", 32'(passo), 32'd5);
        done_cnt = 0;
        repeat (15) begin
            if (done) done_cnt++;
            tick();
        end
        check("t6_no_done", 32'(done_cnt), 32'd0);
        check("t6_hold",    32'(saida), 32'h014);

        // Abort in IDLE has no effect on a start
        abort = 1'b1;
        start_op(12'h000, 12'h5A3, 1'b0);
        abort = 1'b0;
        check("t7_busy", 32'(busy), 32'h1);
        repeat (12) tick();
        check("t7_saida", 32'(saida), 32'h5A3);
        tick();

        // Asynchronous reset mid-operation, then a clean run
        start_op(12'h000, 12'hA5C, 1'b0);
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        check("t8_saida", 32'(saida), 32'h0);
        check("t8_busy",  32'(busy), 32'h0);
        check("t8_passo", 32'(passo), 32'h0);
        check("t8_done",  32'(done), 32'h0);
        #1 rst = 1'b0;
        tick();
        check("t8_idle", 32'(busy), 32'h0);
        start_op(12'h000, 12'h3C1, 1'b0);
        repeat (12) tick();
        check("t8_saida_run", 32'(saida), 32'h3C1);
        check("t8_done_run",  32'(done), 32'h1);
        check("t8_passo_run", 32'(passo), 32'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
